prog_loader: RTL and testbench

Boot and run sequencer for `CPU_Core`. It takes a byte stream from the UART receiver, packs it into 32-bit words and writes them into instruction memory. It then releases the core by driving its `uart_done_reg` input and waits for the core's `halt_flag`. Optionally, it dumps the first words of data memory back out over the UART transmitter.

---
 rtl/prog_loader_pkg.sv | 15 +
 rtl/prog_loader_byte_packer.sv | 34 +++
 rtl/prog_loader.sv | 165 ++++++++++++++++
 tb/tb_prog_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DUMP = 3'd3,
    ST_DONE = 3'd4
  } loader_state_t;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words with a one-cycle word strobe.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [BYTE_IDX_W-1:0] idx_q;

  // Byte lane fill; the strobe follows the edge that takes the last lane
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        idx_q <= '0;
      end else if (byte_valid) begin
        word_data[{idx_q, 3'b000} +: 8] <= byte_data;
        idx_q <= idx_q + BYTE_IDX_W'(1);
        if (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1)) word_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot/run sequencer: loads imem from UART bytes, runs the core until halt,
// then optionally dumps dmem over UART tx (macro PROG_LOADER_DUMP_EN).
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 64,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DUMP_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_run,
  input  logic              core_halt,
  output logic [ADDR_W-1:0] dmem_raddr,
  input  logic [31:0]       dmem_rdata,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  loader_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, n_q, cnt_inc;
  logic             hdr_in_range, hdr_ok, hdr_bad;
  logic             word_valid;
  logic [31:0]      word_data;
  logic             run_q, busy_q, err_q;
  logic             dump_end;

  assign cnt_inc      = cnt_q + CNT_W'(1);
  assign hdr_in_range = (rx_data != 8'd0) && (32'(rx_data) <= MEM_WORDS);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (hdr_ok),
    .byte_valid (rx_valid && (state_q == ST_LOAD)),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and header decode
  always_comb begin
    state_d = state_q;
    hdr_ok  = 1'b0;
    hdr_bad = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (rx_valid) begin
          if (hdr_in_range) begin
            hdr_ok  = 1'b1;
            state_d = ST_LOAD;
          end else begin
            hdr_bad = 1'b1;
          end
        end
      end
      ST_LOAD: if (word_valid && (cnt_inc == n_q)) state_d = ST_RUN;
`ifdef PROG_LOADER_DUMP_EN
      ST_RUN:  if (core_halt) state_d = ST_DUMP;
`else
      ST_RUN:  if (core_halt) state_d = ST_DONE;
`endif
      ST_DUMP: if (dump_end) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Word counter, header latch, sticky error and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      n_q    <= '0;
      err_q  <= 1'b0;
      run_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      run_q  <= (state_d == ST_RUN);
      busy_q <= (state_d inside {ST_LOAD, ST_RUN, ST_DUMP});
      if (hdr_ok) begin
        cnt_q <= '0;
        n_q   <= CNT_W'(rx_data);
        err_q <= 1'b0;
      end else begin
        if (hdr_bad) err_q <= 1'b1;
        if ((state_q == ST_LOAD) && word_valid) cnt_q <= cnt_inc;
      end
    end
  end

  assign imem_we    = word_valid;
  assign imem_addr  = cnt_q[ADDR_W-1:0];
  assign imem_wdata = word_data;
  assign core_run   = run_q;
  assign busy       = busy_q;
  assign err        = err_q;

`ifdef PROG_LOADER_DUMP_EN
  logic [ADDR_W-1:0]     raddr_q;
  logic                  tx_valid_q;
  logic [7:0]            tx_data_q;
  logic [BYTE_IDX_W-1:0] bidx_q, bidx_nx;
  logic                  last_word;

  assign bidx_nx   = bidx_q + BYTE_IDX_W'(1);
  assign last_word = (raddr_q == ADDR_W'(DUMP_WORDS - 1));
  assign dump_end  = tx_valid_q && tx_ready && last_word &&
                     (bidx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

  // Dump serializer: address set up one cycle ahead, then four LSB-first bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      bidx_q     <= '0;
    end else if ((state_q == ST_RUN) && core_halt) begin
      raddr_q    <= '0;
      tx_valid_q <= 1'b0;
      bidx_q     <= '0;
    end else if (state_q == ST_DUMP) begin
      if (!tx_valid_q) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= dmem_rdata[7:0];
        bidx_q     <= '0;
      end else if (tx_ready) begin
        if (bidx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1)) begin
          tx_valid_q <= 1'b0;
          if (!last_word) raddr_q <= raddr_q + ADDR_W'(1);
        end else begin
          bidx_q    <= bidx_nx;
          tx_data_q <= dmem_rdata[{bidx_nx, 3'b000} +: 8];
        end
      end
    end
  end

  assign dmem_raddr = raddr_q;
  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
`else
  logic unused_dump;
  assign unused_dump = ^{tx_ready, dmem_rdata, 32'(DUMP_WORDS)};
  assign dump_end    = 1'b0;
  assign dmem_raddr  = '0;
  assign tx_valid    = 1'b0;
  assign tx_data     = '0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; covers both builds of PROG_LOADER_DUMP_EN.
module tb_prog_loader;

  localparam int unsigned MEM_WORDS  = 64;
  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned DUMP_WORDS = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_run;
  logic              core_halt;
  logic [ADDR_W-1:0] dmem_raddr;
  logic [31:0]       dmem_rdata;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              busy;
  logic              err;

  int n_checks = 0;
  int n_pass   = 0;
  int we_cnt   = 0;
  bit tx_seen  = 1'b0;

  prog_loader #(
    .MEM_WORDS  (MEM_WORDS),
    .ADDR_W     (ADDR_W),
    .DUMP_WORDS (DUMP_WORDS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_run   (core_run),
    .core_halt  (core_halt),
    .dmem_raddr (dmem_raddr),
    .dmem_rdata (dmem_rdata),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Data memory contents: word 0 is AABBCCDD, word w>0 holds bytes 4w..4w+3
  always_comb begin
    if (dmem_raddr == '0) dmem_rdata = 32'hAABBCCDD;
    else dmem_rdata = {8'(4*dmem_raddr+3), 8'(4*dmem_raddr+2),
                       8'(4*dmem_raddr+1), 8'(4*dmem_raddr)};
  end

  // Count write strobes and note any tx offer
  always @(negedge clk) begin
    if (imem_we)  we_cnt  <= we_cnt + 1;
    if (tx_valid) tx_seen <= 1'b1;
  end

  function automatic logic [7:0] exp_byte(input int idx);
    logic [7:0] w0 [4];
    w0 = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    if (idx < 4) return w0[idx];
    return 8'(idx);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"},    32'(imem_we),    32'd0);
    check({tag, "_addr"},  32'(imem_addr),  32'd0);
    check({tag, "_run"},   32'(core_run),   32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_err"},   32'(err),        32'd0);
    check({tag, "_txv"},   32'(tx_valid),   32'd0);
    check({tag, "_raddr"}, 32'(dmem_raddr), 32'd0);
  endtask

  initial begin
    int we_base;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    core_halt = 1'b0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_wdata", imem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Out-of-range headers set err and stay idle
    send_byte(8'h00);
    check("hdr0_err",  32'(err),  32'd1);
    check("hdr0_busy", 32'(busy), 32'd0);
    send_byte(8'h41);
    check("hdr41_err",  32'(err),  32'd1);
    check("hdr41_busy", 32'(busy), 32'd0);
    @(negedge clk); #1;
    check("hdr_bad_no_we", 32'(we_cnt), 32'd0);
    @(negedge clk);
    send_byte(8'h01);
    check("hdr1_err",  32'(err),  32'd0);
    check("hdr1_busy", 32'(busy), 32'd1);

    // Abort this load, then a 2-word load reset partway through word 1
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    send_byte(8'h02);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    check("pre_we0",   32'(imem_we),   32'd1);
    check("pre_addr0", 32'(imem_addr), 32'd0);
    send_byte(8'h93); send_byte(8'h00);
    check("pre_addr_cnt", 32'(imem_addr), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Full 2-word load with an idle gap between words
    #1 we_base = we_cnt;
    send_byte(8'h02);
    check("load_busy", 32'(busy), 32'd1);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    check("w0_we",    32'(imem_we),   32'd1);
    check("w0_addr",  32'(imem_addr), 32'd0);
    check("w0_wdata", imem_wdata,     32'h00100013);
    @(negedge clk);
    check("gap_we",  32'(imem_we),  32'd0);
    check("gap_run", 32'(core_run), 32'd0);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00);
    check("w1_we",    32'(imem_we),   32'd1);
    check("w1_addr",  32'(imem_addr), 32'd1);
    check("w1_wdata", imem_wdata,     32'h00200093);
    check("w1_run",   32'(core_run),  32'd0);
    @(negedge clk);
    check("run_rise", 32'(core_run), 32'd1);
    check("run_busy", 32'(busy),     32'd1);
    check("run_we",   32'(imem_we),  32'd0);
    send_byte(8'hFF);
    #1;
    check("run_rx_ignored", 32'(imem_we), 32'd0);
    check("we_total", 32'(we_cnt - we_base), 32'd2);
    check("run_hold", 32'(core_run), 32'd1);

`ifdef PROG_LOADER_DUMP_EN
    begin
      int got;
      int cyc;
      bit stalled;
      got = 0; cyc = 0; stalled = 1'b0;
      @(negedge clk);
      core_halt = 1'b1;
      tx_ready  = 1'b1;
      @(negedge clk);
      check("dump_run_fall", 32'(core_run),   32'd0);
      check("dump_busy",     32'(busy),       32'd1);
      check("dump_raddr0",   32'(dmem_raddr), 32'd0);
      check("dump_txv0",     32'(tx_valid),   32'd0);
      while (got < int'(DUMP_WORDS * 4) && cyc < 2000) begin
        @(negedge clk);
        cyc++;
        if (got == 10 && !stalled) begin
          stalled  = 1'b1;
          tx_ready = 1'b0;
          for (int s = 0; s < 5; s++) begin
            check("stall_valid", 32'(tx_valid), 32'd1);
            check("stall_data",  32'(tx_data),  32'(exp_byte(got)));
            @(negedge clk);
          end
          tx_ready = 1'b1;
        end
        if (tx_valid) begin
          check("tx_byte", 32'(tx_data), 32'(exp_byte(got)));
          if (got % 4 == 0) check("tx_raddr", 32'(dmem_raddr), 32'(got / 4));
          got++;
        end
      end
      check("dump_count", 32'(got), 32'(DUMP_WORDS * 4));
      @(negedge clk);
      check("done_busy", 32'(busy),     32'd0);
      check("done_run",  32'(core_run), 32'd0);
      check("done_txv",  32'(tx_valid), 32'd0);
      repeat (3) @(negedge clk);
      check("done_txv_quiet", 32'(tx_valid), 32'd0);
    end
`else
    @(negedge clk);
    core_halt = 1'b1;
    tx_ready  = 1'b1;
    @(negedge clk);
    check("nodump_run_fall", 32'(core_run),   32'd0);
    check("nodump_busy",     32'(busy),       32'd0);
    check("nodump_txv",      32'(tx_valid),   32'd0);
    check("nodump_raddr",    32'(dmem_raddr), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("nodump_tx_never", 32'(tx_seen), 32'd0);
`endif

    // Headers in DONE: bad one flags err, good one restarts a load
    send_byte(8'h00);
    check("done_hdr0_err",  32'(err),  32'd1);
    check("done_hdr0_busy", 32'(busy), 32'd0);
    send_byte(8'h01);
    check("done_hdr1_err",  32'(err),  32'd0);
    check("done_hdr1_busy", 32'(busy), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
